// File: rtl/gbemac_pkg.sv
// Shared types and constants for the gigabit MAC transmit/receive paths.
package gbemac_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_DROP,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32, LSB of the byte first.
module crc32_d8
  import gbemac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps an upstream byte stream with preamble, SFD, zero pad
// and FCS, marks underrun/abort with tx_er, and holds off the next frame for the IFG.
module gmii_tx_framer
  import gbemac_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_DATA_LEN = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       reset_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_DATA_LEN);
  localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);

  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [15:0] byte_cnt_q;
  logic [15:0] byte_cnt_inc;
  logic [31:0] crc_q;
  logic [31:0] crc_nxt;
  logic [31:0] fcs;
  logic [7:0]  crc_data;
  logic [7:0]  fcs_byte;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        tx_done_q;
  logic        tx_abort_q;
  logic        s_tready_q;
  logic        tlast_seen_q;
  logic        need_pad;

  assign byte_cnt_inc = sat_inc16(byte_cnt_q);
  assign need_pad     = (MIN_DATA_LEN > 0) && (byte_cnt_inc < MIN_LEN);
  assign crc_data     = (state_q == ST_PAD) ? 8'h00 : s_tdata;
  assign fcs          = ~crc_q;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (crc_data),
    .crc_out (crc_nxt)
  );

  // Each state decides what goes on the wire in the following cycle.
  always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      byte_cnt_q   <= 16'd0;
      crc_q        <= CRC_INIT;
      txd_q        <= 8'h00;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_abort_q   <= 1'b0;
      s_tready_q   <= 1'b0;
      tlast_seen_q <= 1'b0;
    end else begin
      tx_done_q  <= 1'b0;
      tx_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          txd_q      <= 8'h00;
          tx_en_q    <= 1'b0;
          tx_er_q    <= 1'b0;
          s_tready_q <= 1'b0;
          if (s_tvalid) begin
            crc_q      <= CRC_INIT;
            byte_cnt_q <= 16'd0;
            tx_en_q    <= 1'b1;
            if (PREAMBLE_LEN > 1) begin
              txd_q   <= PREAMBLE_BYTE;
              cnt_q   <= 16'd1;
              state_q <= ST_PRE;
            end else if (PREAMBLE_LEN == 1) begin
              txd_q   <= PREAMBLE_BYTE;
              state_q <= ST_SFD;
            end else begin
              txd_q      <= SFD_BYTE;
              s_tready_q <= 1'b1;
              state_q    <= ST_DATA;
            end
          end
        end

        ST_PRE: begin
          txd_q   <= PREAMBLE_BYTE;
          tx_en_q <= 1'b1;
          cnt_q   <= cnt_q + 16'd1;
          if (cnt_q >= PRE_LAST) state_q <= ST_SFD;
        end

        // Ready goes high here so the first data byte lands right after the SFD.
        ST_SFD: begin
          txd_q      <= SFD_BYTE;
          tx_en_q    <= 1'b1;
          s_tready_q <= 1'b1;
          state_q    <= ST_DATA;
        end

        ST_DATA: begin
          if (!s_tvalid || s_tuser) begin
            txd_q        <= 8'h00;
            tx_en_q      <= 1'b1;
            tx_er_q      <= 1'b1;
            tx_abort_q   <= 1'b1;
            s_tready_q   <= 1'b0;
            tlast_seen_q <= s_tvalid & s_tuser & s_tlast;
            state_q      <= ST_ABORT;
          end else begin
            txd_q      <= s_tdata;
            tx_en_q    <= 1'b1;
            crc_q      <= crc_nxt;
            byte_cnt_q <= byte_cnt_inc;
            if (s_tlast) begin
              s_tready_q <= 1'b0;
              cnt_q      <= 16'd0;
              state_q    <= need_pad ? ST_PAD : ST_FCS;
            end
          end
        end

        ST_PAD: begin
          txd_q      <= 8'h00;
          tx_en_q    <= 1'b1;
          crc_q      <= crc_nxt;
          byte_cnt_q <= byte_cnt_inc;
          if (byte_cnt_inc >= MIN_LEN) begin
            cnt_q   <= 16'd0;
            state_q <= ST_FCS;
          end
        end

        ST_FCS: begin
          txd_q   <= fcs_byte;
          tx_en_q <= 1'b1;
          cnt_q   <= cnt_q + 16'd1;
          if (cnt_q[1:0] == 2'd3) begin
            tx_done_q <= 1'b1;
            cnt_q     <= 16'd0;
            state_q   <= (IFG_LEN == 0) ? ST_IDLE : ST_IFG;
          end
        end

        // The marker cycle itself counts as the first gap cycle when tlast came with it.
        ST_ABORT: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (tlast_seen_q) begin
            s_tready_q <= 1'b0;
            cnt_q      <= 16'd1;
            state_q    <= (IFG_LEN <= 1) ? ST_IDLE : ST_IFG;
          end else begin
            s_tready_q <= 1'b1;
            state_q    <= ST_DROP;
          end
        end

        ST_DROP: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          tx_er_q <= 1'b0;
          if (s_tvalid && s_tlast) begin
            s_tready_q <= 1'b0;
            cnt_q      <= 16'd0;
            state_q    <= (IFG_LEN == 0) ? ST_IDLE : ST_IFG;
          end
        end

        ST_IFG: begin
          txd_q      <= 8'h00;
          tx_en_q    <= 1'b0;
          tx_er_q    <= 1'b0;
          s_tready_q <= 1'b0;
          cnt_q      <= cnt_q + 16'd1;
          if (cnt_q >= IFG_LAST) begin
            cnt_q   <= 16'd0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          txd_q      <= 8'h00;
          tx_en_q    <= 1'b0;
          tx_er_q    <= 1'b0;
          s_tready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign tx_done    = tx_done_q;
  assign tx_abort   = tx_abort_q;
  assign s_tready   = s_tready_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: random frames against a table-driven frame model.
module tb_gmii_tx_framer;

  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] wq_t[$];

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       reset_n;
  logic [7:0] s_tdata;
  logic       s_tlast, s_tuser, vld1, vld2;
  logic       rdy1, rdy2;
  logic [7:0] txd1, txd2;
  logic       en1, en2, er1, er2, done1, done2, ab1, ab2;

  gmii_tx_framer dut1 (
    .gmii_tx_clk (clk),     .reset_n    (reset_n),
    .s_tdata     (s_tdata), .s_tvalid   (vld1),    .s_tready (rdy1),
    .s_tlast     (s_tlast), .s_tuser    (s_tuser),
    .gmii_txd    (txd1),    .gmii_tx_en (en1),     .gmii_tx_er (er1),
    .tx_done     (done1),   .tx_abort   (ab1)
  );

  gmii_tx_framer #(.MIN_DATA_LEN(0)) dut2 (
    .gmii_tx_clk (clk),     .reset_n    (reset_n),
    .s_tdata     (s_tdata), .s_tvalid   (vld2),    .s_tready (rdy2),
    .s_tlast     (s_tlast), .s_tuser    (s_tuser),
    .gmii_txd    (txd2),    .gmii_tx_en (en2),     .gmii_tx_er (er2),
    .tx_done     (done2),   .tx_abort   (ab2)
  );

  int errors = 0, checks = 0, timeouts = 0;
  logic [31:0] crc_tab [256];

  // Wire monitor: everything is sampled on the falling edge.
  wq_t  wq, wq2;
  int   cyc = 0, flen = 0, acc_cnt = 0, ready_gap = 0, done2_cnt = 0, ab2_cnt = 0;
  logic prev_en = 1'b0, in_gap = 1'b0;
  int   rise_cyc[$], done_cyc[$], done_len[$], abort_cyc[$], tlast_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (en1 && !prev_en) begin rise_cyc.push_back(cyc); flen = 0; in_gap = 1'b0; end
    if (en1) begin flen++; wq.push_back({er1, txd1}); end
    if (done1) begin done_cyc.push_back(cyc); done_len.push_back(flen); in_gap = 1'b1; end
    if (in_gap && rdy1) ready_gap++;
    if (ab1) abort_cyc.push_back(cyc);
    if (vld1 && rdy1) begin acc_cnt++; if (s_tlast) tlast_cyc.push_back(cyc); end
    if (en2) wq2.push_back({er2, txd2});
    if (done2) done2_cnt++;
    if (ab2) ab2_cnt++;
    prev_en = en1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1000000;
  endfunction

  function automatic logic [31:0] crc_run(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) c = crc_tab[c[7:0] ^ d[i]] ^ (c >> 8);
    return c;
  endfunction

  // Expected wire stream of a good frame: preamble, SFD, data, zero pad, ~CRC LSB first.
  function automatic wq_t frame_model(input bq_t data, input int min_len);
    wq_t s;
    bq_t body;
    logic [31:0] f;
    body = data;
    while (body.size() < min_len) body.push_back(8'h00);
    for (int i = 0; i < 7; i++) s.push_back({1'b0, 8'h55});
    s.push_back({1'b0, 8'hD5});
    foreach (body[i]) s.push_back({1'b0, body[i]});
    f = ~crc_run(body);
    for (int i = 0; i < 4; i++) s.push_back({1'b0, 8'(f >> (8 * i))});
    return s;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t d;
    for (int i = 0; i < n; i++) d.push_back(8'($urandom_range(0, 255)));
    return d;
  endfunction

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic last, input logic user);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    s_tdata = b; s_tlast = last; s_tuser = user;
    if (sel) vld2 = 1'b1; else vld1 = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = sel ? rdy2 : rdy1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) timeouts++;
  endtask

  task automatic send_frame(input bit sel, input bq_t d, input int user_at);
    for (int i = 0; i < d.size(); i++)
      send_byte(sel, d[i], 1'(i == d.size() - 1), 1'(i == user_at));
  endtask

  task automatic idle_in();
    vld1 = 1'b0; vld2 = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic wait_q(input bit sel, input int target);
    int n;
    n = 0;
    while (((sel ? wq2.size() : wq.size()) < target) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) timeouts++;
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_stream(input string tag, input bit sel, input int base, input wq_t exp);
    logic [8:0] o;
    for (int i = 0; i < exp.size(); i++) begin
      int e0;
      e0 = errors;
      if (sel) o = (base + i < wq2.size()) ? wq2[base + i] : 9'bx;
      else     o = (base + i < wq.size())  ? wq[base + i]  : 9'bx;
      check($sformatf("%s[%0d]", tag, i), 32'(o), 32'(exp[i]));
      if (errors != e0) break;
    end
  endtask

  initial begin
    bq_t d, dn, r;
    wq_t e, en_exp;
    int base, base2, nd, na, nr, nt, acc0, rg, d2;
    logic [31:0] t;

    for (int n = 0; n < 256; n++) begin
      t = 32'(n);
      for (int k = 0; k < 8; k++) t = t[0] ? ((t >> 1) ^ 32'hEDB88320) : (t >> 1);
      crc_tab[n] = t;
    end

    reset_n = 1'b0; s_tdata = 8'h00;
    idle_in();
    #20;
    check("rst_txd", 32'(txd1), 32'h0);
    check("rst_en", 32'(en1), 32'h0);
    check("rst_er", 32'(er1), 32'h0);
    check("rst_ready", 32'(rdy1), 32'h0);
    check("rst_done", 32'(done1), 32'h0);
    check("rst_abort", 32'(ab1), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 60-byte frame, continuous valid
    d = rand_bytes(60); base = wq.size(); nd = done_cyc.size();
    send_frame(0, d, -1); idle_in();
    wait_q(0, base + 72);
    cmp_stream("f60", 0, base, frame_model(d, 60));
    check("f60_done_pos", 32'(qget(done_len, nd)), 32'd72);
    r = {};
    for (int i = 8; i < 72; i++) r.push_back(wq[base + i][7:0]);
    check("f60_residue", crc_run(r), 32'hDEBB20E3);

    // 14-byte frame padded to 60
    d = rand_bytes(14); base = wq.size(); nd = done_cyc.size();
    send_frame(0, d, -1); idle_in();
    wait_q(0, base + 72);
    cmp_stream("f14pad", 0, base, frame_model(d, 60));
    check("f14_done_pos", 32'(qget(done_len, nd)), 32'd72);

    // back-to-back frames with valid held high
    d = rand_bytes($urandom_range(15, 50)); dn = rand_bytes($urandom_range(61, 120));
    e = frame_model(d, 60); en_exp = frame_model(dn, 60);
    base = wq.size(); nd = done_cyc.size(); nr = rise_cyc.size(); rg = ready_gap;
    send_frame(0, d, -1); send_frame(0, dn, -1); idle_in();
    wait_q(0, base + e.size() + en_exp.size());
    cmp_stream("b2b_a", 0, base, e);
    cmp_stream("b2b_b", 0, base + e.size(), en_exp);
    check("b2b_gap", 32'(qget(rise_cyc, nr + 1) - qget(done_cyc, nd) - 1), 32'd12);
    check("b2b_ready_in_ifg", 32'(ready_gap - rg), 32'd0);

    // underrun after 20 bytes of a 100-byte frame, then a fresh frame
    d = rand_bytes(100); dn = rand_bytes(64);
    base = wq.size(); nd = done_cyc.size(); na = abort_cyc.size();
    nr = rise_cyc.size(); nt = tlast_cyc.size(); acc0 = acc_cnt;
    for (int i = 0; i < 20; i++) send_byte(0, d[i], 1'b0, 1'b0);
    vld1 = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 20; i < 100; i++) send_byte(0, d[i], 1'(i == 99), 1'b0);
    check("ur_no_fcs", 32'(done_cyc.size() - nd), 32'd0);
    check("ur_accepted", 32'(acc_cnt - acc0), 32'd100);
    send_frame(0, dn, -1); idle_in();
    en_exp = frame_model(dn, 60);
    wait_q(0, base + 29 + en_exp.size());
    e = frame_model(d, 60);
    e = e[0:27];
    e.push_back(9'h100);
    cmp_stream("ur_frame", 0, base, e);
    cmp_stream("ur_next", 0, base + 29, en_exp);
    check("ur_abort_pulses", 32'(abort_cyc.size() - na), 32'd1);
    check("ur_gap_ge_ifg", 32'((qget(rise_cyc, nr + 1) - qget(tlast_cyc, nt) - 1) >= 12), 32'd1);

    // abort marker and tlast on the same beat, then a fresh frame
    d = rand_bytes(30); dn = rand_bytes(20);
    base = wq.size(); nd = done_cyc.size(); na = abort_cyc.size(); nr = rise_cyc.size();
    send_frame(0, d, 29); send_frame(0, dn, -1); idle_in();
    en_exp = frame_model(dn, 60);
    wait_q(0, base + 38 + en_exp.size());
    e = frame_model(d, 60);
    e = e[0:36];
    e.push_back(9'h100);
    cmp_stream("usr_frame", 0, base, e);
    cmp_stream("usr_next", 0, base + 38, en_exp);
    check("usr_gap", 32'(qget(rise_cyc, nr + 1) - qget(abort_cyc, na) - 1), 32'd12);
    check("usr_done_count", 32'(done_cyc.size() - nd), 32'd1);

    // reset in the middle of DATA
    vld1 = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0;
    repeat (20) begin
      s_tdata = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    check("mid_en_before_rst", 32'(en1), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(en1), 32'h0);
    check("mid_rst_er", 32'(er1), 32'h0);
    check("mid_rst_txd", 32'(txd1), 32'h0);
    check("mid_rst_ready", 32'(rdy1), 32'h0);
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    d = rand_bytes(45); base = wq.size();
    send_frame(0, d, -1); idle_in();
    wait_q(0, base + 72);
    cmp_stream("post_rst", 0, base, frame_model(d, 60));

    // no padding instance: check value of "123456789"
    d = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    base2 = wq2.size(); d2 = done2_cnt;
    send_frame(1, d, -1); idle_in();
    wait_q(1, base2 + 21);
    cmp_stream("nopad", 1, base2, frame_model(d, 0));
    check("nopad_fcs0", 32'(wq2[base2 + 17]), 32'h026);
    check("nopad_fcs1", 32'(wq2[base2 + 18]), 32'h039);
    check("nopad_fcs2", 32'(wq2[base2 + 19]), 32'h0F4);
    check("nopad_fcs3", 32'(wq2[base2 + 20]), 32'h0CB);
    check("nopad_len", 32'(wq2.size() - base2), 32'd21);
    check("nopad_done", 32'(done2_cnt - d2), 32'd1);
    check("nopad_no_abort", 32'(ab2_cnt), 32'd0);

    check("no_timeouts", 32'(timeouts), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
